// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : Multi-lane valid/ready pipeline stage with a two-entry skid
//            buffer, synchronous flush and saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int WIDTH = 32,
    parameter int LANES = 2,
    parameter int CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   CLR,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    localparam int c_DATA_W = LANES * WIDTH;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_DATA_W-1:0] main_q, main_d;
    logic [c_DATA_W-1:0] skid_q, skid_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0]    flush_q, flush_d;

    logic w_accept;
    logic w_fire;
    logic w_valid;

    assign w_valid  = (state_q != S_EMPTY);
    assign w_accept = in_valid & in_ready_q;
    assign w_fire   = w_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            S_EMPTY: begin
                if (w_accept) begin
                    state_d = S_ONE;
                    main_d  = in_data;
                end
            end
            S_ONE: begin
                if (w_accept && w_fire) begin
                    main_d = in_data;
                end else if (w_accept) begin
                    state_d = S_TWO;
                    skid_d  = in_data;
                end else if (w_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_fire) begin
                    state_d = S_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // Flush discards both entries and any beat accepted this cycle.
        if (CLR) begin
            state_d = S_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end

        in_ready_d = CLR ? 1'b1 : (state_d != S_TWO);

        stall_d = stall_q;
        if (w_valid && !out_ready && !CLR && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end

        flush_d = flush_q;
        if (CLR && w_valid && (flush_q != {CNT_W{1'b1}})) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = w_valid;
    assign out_data  = main_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule
`default_nettype wire
